game_handler_param: RTL and testbench

//  Parametrised successor to the hangman round controller. Owns the round state

---
 rtl/hangman_pkg.sv | 18 +
 rtl/hangman_guess_unit.sv | 51 +++++
 rtl/game_handler_param.sv | 113 +++++++++++
 tb/tb_game_handler_param.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared definitions for the parametrised hangman round controller.
//   game_st_t      : round state encoding, also driven out as game_state
//   new_game_code  : command code that starts a new round (one past the
//                    last letter code)
package hangman_pkg;

    typedef enum logic [1:0] {
        ST_START  = 2'd0,
        ST_INGAME = 2'd1,
        ST_WIN    = 2'd2,
        ST_LOST   = 2'd3
    } game_st_t;

    function automatic int new_game_code(input int alpha);
        return alpha;
    endfunction

endpackage

// File: rtl/hangman_guess_unit.sv
// Combinational evaluation of one letter guess against the round masks.
//   letter        in  CMD_W  command code (only codes < ALPHA are letters)
//   word_mask     in  ALPHA  latched secret letter set
//   guessed_mask  in  ALPHA  letters already found
//   tried_mask    in  ALPHA  letters already tried
//   is_letter     out 1      code is a valid letter
//   hit           out 1      new letter present in the word
//   miss          out 1      new letter absent from the word
//   repeated      out 1      letter was already tried
//   repeat_miss   out 1      repeated letter that is absent from the word
//   all_found     out 1      guessed set plus this letter covers the word
//   guessed_next  out ALPHA  guessed set after a hit
//   tried_next    out ALPHA  tried set after this guess
module hangman_guess_unit #(
    parameter int ALPHA = 26,
    parameter int CMD_W = 5
) (
    input  logic [CMD_W-1:0] letter,
    input  logic [ALPHA-1:0] word_mask,
    input  logic [ALPHA-1:0] guessed_mask,
    input  logic [ALPHA-1:0] tried_mask,
    output logic             is_letter,
    output logic             hit,
    output logic             miss,
    output logic             repeated,
    output logic             repeat_miss,
    output logic             all_found,
    output logic [ALPHA-1:0] guessed_next,
    output logic [ALPHA-1:0] tried_next
);

    localparam logic [CMD_W-1:0] ALPHA_C = CMD_W'(ALPHA);

    logic [ALPHA-1:0] sel;
    logic             in_word;

    always_comb begin
        is_letter   = (letter < ALPHA_C);
        sel         = is_letter ? (ALPHA'(1) << letter) : '0;
        in_word     = |(word_mask & sel);
        repeated    = is_letter && |(tried_mask & sel);
        hit         = is_letter && !repeated && in_word;
        miss        = is_letter && !repeated && !in_word;
        repeat_miss = repeated && !in_word;
        // Win test uses the post-guess set so the win lands on the same edge.
        all_found   = ((guessed_mask | sel) == word_mask);
        guessed_next = hit ? (guessed_mask | sel) : guessed_mask;
        tried_next   = tried_mask | sel;
    end

endmodule

// File: rtl/game_handler_param.sv
// Hangman round controller: round FSM, guessed/tried masks, lives counter and
// per-guess status pulses.
//   clk           in  1        system clock
//   reset         in  1        asynchronous, active-high
//   load          in  1        command strobe
//   load_x        in  CMD_W    letter code, or ALPHA for new game
//   mask          in  ALPHA    secret letter set, sampled at new game
//   guessed_mask  out ALPHA    correctly guessed letters
//   tried_mask    out ALPHA    all letters tried this round
//   game_state    out 2        START / INGAME / WINGAME / LOSTGAME
//   wrong_time    out LIVES_W  lives remaining
//   guess_hit     out 1        pulse: new correct letter
//   guess_miss    out 1        pulse: life lost
//   guess_repeat  out 1        pulse: letter already tried
module game_handler_param
    import hangman_pkg::*;
#(
    parameter int ALPHA      = 26,
    parameter int MAX_WRONG  = 5,
    parameter int CMD_W      = 5,
    parameter int LIVES_W    = 4,
    parameter int PEN_REPEAT = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [CMD_W-1:0]   load_x,
    input  logic [ALPHA-1:0]   mask,
    output logic [ALPHA-1:0]   guessed_mask,
    output logic [ALPHA-1:0]   tried_mask,
    output logic [1:0]         game_state,
    output logic [LIVES_W-1:0] wrong_time,
    output logic               guess_hit,
    output logic               guess_miss,
    output logic               guess_repeat
);

    localparam logic [CMD_W-1:0]   NEW_CODE   = CMD_W'(new_game_code(ALPHA));
    localparam logic [LIVES_W-1:0] LIVES_FULL = LIVES_W'(MAX_WRONG);
    localparam logic               PEN        = (PEN_REPEAT != 0);

    game_st_t         state;
    logic [ALPHA-1:0] word_mask;

    logic             g_is_letter, g_hit, g_miss, g_repeat, g_repeat_miss, g_all_found;
    logic [ALPHA-1:0] g_guessed_next, g_tried_next;
    logic             lose_life;
    logic [LIVES_W-1:0] lives_dec;

    hangman_guess_unit #(
        .ALPHA (ALPHA),
        .CMD_W (CMD_W)
    ) u_guess (
        .letter       (load_x),
        .word_mask    (word_mask),
        .guessed_mask (guessed_mask),
        .tried_mask   (tried_mask),
        .is_letter    (g_is_letter),
        .hit          (g_hit),
        .miss         (g_miss),
        .repeated     (g_repeat),
        .repeat_miss  (g_repeat_miss),
        .all_found    (g_all_found),
        .guessed_next (g_guessed_next),
        .tried_next   (g_tried_next)
    );

    assign lose_life  = g_miss | (PEN & g_repeat_miss);
    // Saturating decrement; the counter never wraps below zero.
    assign lives_dec  = (wrong_time != '0) ? (wrong_time - LIVES_W'(1)) : '0;
    assign game_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_START;
            word_mask    <= '0;
            guessed_mask <= '0;
            tried_mask   <= '0;
            wrong_time   <= LIVES_FULL;
            guess_hit    <= 1'b0;
            guess_miss   <= 1'b0;
            guess_repeat <= 1'b0;
        end else begin
            guess_hit    <= 1'b0;
            guess_miss   <= 1'b0;
            guess_repeat <= 1'b0;
            if (load) begin
                if (load_x == NEW_CODE) begin
                    // Accepted in every state, so it doubles as a round abort.
                    word_mask    <= mask;
                    guessed_mask <= '0;
                    tried_mask   <= '0;
                    wrong_time   <= LIVES_FULL;
                    state        <= (mask == '0) ? ST_WIN : ST_INGAME;
                end else if (state == ST_INGAME && g_is_letter) begin
                    guessed_mask <= g_guessed_next;
                    tried_mask   <= g_tried_next;
                    guess_hit    <= g_hit;
                    guess_repeat <= g_repeat;
                    if (lose_life) begin
                        wrong_time <= lives_dec;
                        guess_miss <= 1'b1;
                        if (lives_dec == '0)
                            state <= ST_LOST;
                    end else if (g_hit && g_all_found) begin
                        state <= ST_WIN;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_game_handler_param.sv
module tb_game_handler_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [4:0]  load_x;
    logic [25:0] mask;

    logic [25:0] gm0, tm0, gm1, tm1;
    logic [1:0]  gs0, gs1;
    logic [3:0]  wt0, wt1;
    logic        hit0, miss0, rep0, hit1, miss1, rep1;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    game_handler_param #(.PEN_REPEAT(0)) dut0 (
        .clk(clk), .reset(reset), .load(load), .load_x(load_x), .mask(mask),
        .guessed_mask(gm0), .tried_mask(tm0), .game_state(gs0), .wrong_time(wt0),
        .guess_hit(hit0), .guess_miss(miss0), .guess_repeat(rep0)
    );

    game_handler_param #(.PEN_REPEAT(1)) dut1 (
        .clk(clk), .reset(reset), .load(load), .load_x(load_x), .mask(mask),
        .guessed_mask(gm1), .tried_mask(tm1), .game_state(gs1), .wrong_time(wt1),
        .guess_hit(hit1), .guess_miss(miss1), .guess_repeat(rep1)
    );

    // {game_state, wrong_time, hit, miss, repeat}
    wire [8:0] st0 = {gs0, wt0, hit0, miss0, rep0};
    wire [8:0] st1 = {gs1, wt1, hit1, miss1, rep1};

    localparam logic [4:0]  NEWG = 5'd26;
    localparam logic [25:0] CAT  = 26'h0080005;  // A=0, C=2, T=19

    task automatic cmd(input logic [4:0] x);
        @(negedge clk);
        load   = 1'b1;
        load_x = x;
        @(posedge clk);
        #1;
        load   = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; load_x = '0; mask = '0;
        #12;
        nchecks++;
        if (st0 !== 9'b00_0101_000) begin nerr++; $display("FAIL reset_state got %b exp %b", st0, 9'b00_0101_000); end
        nchecks++;
        if ({gm0, tm0} !== 52'd0) begin nerr++; $display("FAIL reset_masks got %h exp 0", {gm0, tm0}); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_win();
        mask = CAT;
        cmd(NEWG);
        nchecks++;
        if (st0 !== 9'b01_0101_000) begin nerr++; $display("FAIL win_newgame got %b exp %b", st0, 9'b01_0101_000); end
        cmd(5'd2);
        nchecks++;
        if (st0 !== 9'b01_0101_100 || gm0 !== 26'h4 || tm0 !== 26'h4) begin
            nerr++; $display("FAIL win_hit_c got %b/%h/%h exp %b/4/4", st0, gm0, tm0, 9'b01_0101_100);
        end
        cmd(5'd0);
        nchecks++;
        if (st0 !== 9'b01_0101_100 || gm0 !== 26'h5) begin
            nerr++; $display("FAIL win_hit_a got %b/%h exp %b/5", st0, gm0, 9'b01_0101_100);
        end
        cmd(5'd19);
        nchecks++;
        if (st0 !== 9'b10_0101_100 || gm0 !== CAT || tm0 !== CAT) begin
            nerr++; $display("FAIL win_hit_t got %b/%h/%h exp %b/%h/%h", st0, gm0, tm0, 9'b10_0101_100, CAT, CAT);
        end
        idle();
        nchecks++;
        if (st0 !== 9'b10_0101_000) begin nerr++; $display("FAIL win_pulse_drop got %b exp %b", st0, 9'b10_0101_000); end
        cmd(5'd3);
        nchecks++;
        if (st0 !== 9'b10_0101_000 || tm0 !== CAT) begin nerr++; $display("FAIL win_ignore got %b/%h exp %b/%h", st0, tm0, 9'b10_0101_000, CAT); end
    endtask

    task automatic test_lose();
        logic [4:0] lt [5];
        logic [8:0] exp;
        lt[0] = 5'd1; lt[1] = 5'd3; lt[2] = 5'd4; lt[3] = 5'd5; lt[4] = 5'd6;
        mask = 26'h1;
        cmd(NEWG);
        for (int i = 0; i < 5; i++) begin
            cmd(lt[i]);
            exp = {(i == 4) ? 2'd3 : 2'd1, 4'(4 - i), 3'b010};
            nchecks++;
            if (st0 !== exp) begin nerr++; $display("FAIL lose_miss%0d got %b exp %b", i, st0, exp); end
        end
        cmd(5'd7);
        nchecks++;
        if (st0 !== 9'b11_0000_000 || tm0 !== 26'h7A || gm0 !== 26'h0) begin
            nerr++; $display("FAIL lose_ignore got %b/%h exp %b/7a", st0, tm0, 9'b11_0000_000);
        end
    endtask

    task automatic test_repeat();
        mask = 26'h1;
        cmd(NEWG);
        cmd(5'd1);
        nchecks++;
        if (st0 !== 9'b01_0100_010 || st1 !== 9'b01_0100_010) begin
            nerr++; $display("FAIL rep_first got %b/%b exp %b", st0, st1, 9'b01_0100_010);
        end
        cmd(5'd1);
        nchecks++;
        if (st0 !== 9'b01_0100_001 || tm0 !== 26'h2) begin
            nerr++; $display("FAIL rep_free got %b/%h exp %b/2", st0, tm0, 9'b01_0100_001);
        end
        nchecks++;
        if (st1 !== 9'b01_0011_011 || tm1 !== 26'h2) begin
            nerr++; $display("FAIL rep_penal got %b/%h exp %b/2", st1, tm1, 9'b01_0011_011);
        end
    endtask

    task automatic test_abort();
        mask = 26'h1;
        cmd(NEWG);
        cmd(5'd1);
        cmd(5'd3);
        nchecks++;
        if (st0 !== 9'b01_0011_010) begin nerr++; $display("FAIL abort_pre got %b exp %b", st0, 9'b01_0011_010); end
        mask = 26'h2;
        cmd(NEWG);
        nchecks++;
        if (st0 !== 9'b01_0101_000 || gm0 !== 26'h0 || tm0 !== 26'h0) begin
            nerr++; $display("FAIL abort_new got %b/%h/%h exp %b/0/0", st0, gm0, tm0, 9'b01_0101_000);
        end
        mask = 26'h0;  // mid-round change must be ignored
        cmd(5'd0);
        nchecks++;
        if (st0 !== 9'b01_0100_010 || tm0 !== 26'h1) begin
            nerr++; $display("FAIL abort_oldmiss got %b/%h exp %b/1", st0, tm0, 9'b01_0100_010);
        end
        cmd(5'd1);
        nchecks++;
        if (st0 !== 9'b10_0100_100 || gm0 !== 26'h2) begin
            nerr++; $display("FAIL abort_newhit got %b/%h exp %b/2", st0, gm0, 9'b10_0100_100);
        end
    endtask

    task automatic test_empty_and_bad();
        mask = 26'h0;
        cmd(NEWG);
        nchecks++;
        if (st0 !== 9'b10_0101_000) begin nerr++; $display("FAIL empty_win got %b exp %b", st0, 9'b10_0101_000); end
        cmd(5'd31);
        nchecks++;
        if (st0 !== 9'b10_0101_000) begin nerr++; $display("FAIL bad_win got %b exp %b", st0, 9'b10_0101_000); end
        mask = 26'h1;
        cmd(NEWG);
        cmd(5'd31);
        nchecks++;
        if (st0 !== 9'b01_0101_000 || tm0 !== 26'h0) begin
            nerr++; $display("FAIL bad_ingame got %b/%h exp %b/0", st0, tm0, 9'b01_0101_000);
        end
        cmd(5'd27);
        nchecks++;
        if (st0 !== 9'b01_0101_000 || tm0 !== 26'h0) begin
            nerr++; $display("FAIL bad27 got %b/%h exp %b/0", st0, tm0, 9'b01_0101_000);
        end
        cmd(5'd25);  // last valid letter, absent from word
        nchecks++;
        if (st0 !== 9'b01_0100_010 || tm0 !== 26'h2000000) begin
            nerr++; $display("FAIL last_letter got %b/%h exp %b/2000000", st0, tm0, 9'b01_0100_010);
        end
    endtask

    task automatic test_back_to_back_reset();
        mask = CAT;
        cmd(NEWG);
        cmd(5'd2);
        nchecks++;
        if (hit0 !== 1'b1) begin nerr++; $display("FAIL rst_prehit got %b exp 1", hit0); end
        reset = 1'b1;
        #1;
        nchecks++;
        if (st0 !== 9'b00_0101_000 || gm0 !== 26'h0 || tm0 !== 26'h0) begin
            nerr++; $display("FAIL rst_mid got %b/%h/%h exp %b/0/0", st0, gm0, tm0, 9'b00_0101_000);
        end
        @(negedge clk);
        reset = 1'b0;
        cmd(5'd31);
        cmd(5'd2);
        nchecks++;
        if (st0 !== 9'b00_0101_000 || tm0 !== 26'h0) begin
            nerr++; $display("FAIL start_ignore got %b/%h exp %b/0", st0, tm0, 9'b00_0101_000);
        end
        mask = 26'h4;
        cmd(NEWG);
        cmd(5'd2);
        nchecks++;
        if (st0 !== 9'b10_0101_100 || gm0 !== 26'h4) begin
            nerr++; $display("FAIL recover got %b/%h exp %b/4", st0, gm0, 9'b10_0101_100);
        end
    endtask

    initial begin
        test_reset();
        test_win();
        test_lose();
        test_repeat();
        test_abort();
        test_empty_and_bad();
        test_back_to_back_reset();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
